// File: rtl/serial_to_parallel.sv
// Receive side of the MRAM serial link: assembles an MSB-first bitstream into a
// 16-bit word (full, lower-byte or upper-byte frames) behind a valid/ack handshake.
module serial_to_parallel #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        start,
    input  logic [1:0]  word_sel,
    input  logic        serial_in,
    input  logic        bit_valid,
    input  logic        word_ack,
    output logic [15:0] data_out,
    output logic        word_valid,
    output logic        busy,
    output logic [4:0]  bit_count,
    output logic        frame_err
);

    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   shift_q, shift_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [TW-1:0] idle_q, idle_d;

    logic [4:0]    target;
    logic [4:0]    cnt_inc;
    logic [15:0]   shift_in;

    function automatic logic sel_ok(input logic [1:0] s);
        return s != 2'b00;
    endfunction

    assign target   = (sel_q == 2'b11) ? 5'd16 : 5'd8;
    assign cnt_inc  = cnt_q + 5'd1;
    assign shift_in = {shift_q[14:0], serial_in};

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        idle_d  = idle_q;
        err_d   = 1'b0;

        if (en) begin
            case (state_q)
                S_IDLE: begin
                    cnt_d  = '0;
                    idle_d = '0;
                    if (start) begin
                        if (sel_ok(word_sel)) begin
                            sel_d   = word_sel;
                            shift_d = '0;
                            state_d = S_RECV;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end

                S_RECV: begin
                    if (start) begin
                        // restart discards the partial frame; an invalid select aborts to IDLE
                        err_d   = 1'b1;
                        shift_d = '0;
                        cnt_d   = '0;
                        idle_d  = '0;
                        if (sel_ok(word_sel)) begin
                            sel_d   = word_sel;
                            state_d = S_RECV;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (bit_valid) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_inc;
                        idle_d  = '0;
                        if (cnt_inc == target) begin
                            state_d = S_DONE;
                            valid_d = 1'b1;
                            case (sel_q)
                                2'b01:   data_d = {data_q[15:8], shift_in[7:0]};
                                2'b10:   data_d = {shift_in[7:0], data_q[7:0]};
                                default: data_d = shift_in;
                            endcase
                        end
                    end else if (TIMEOUT_CYCLES != 0 && idle_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end

                S_DONE: begin
                    if (bit_valid) begin
                        err_d = 1'b1;
                    end
                    if (word_ack) begin
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        idle_d  = '0;
                        state_d = S_IDLE;
                        if (start) begin
                            if (sel_ok(word_sel)) begin
                                sel_d   = word_sel;
                                shift_d = '0;
                                state_d = S_RECV;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end else if (start) begin
                        err_d = 1'b1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    idle_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            idle_q  <= idle_d;
        end
    end

    assign data_out   = data_q;
    assign word_valid = valid_q;
    assign busy       = (state_q != S_IDLE);
    assign bit_count  = cnt_q;
    assign frame_err  = err_q & en;

endmodule
